esp_trees_sched: RTL and testbench

ESP_TREES_SCHED -- requirements
Module: esp_trees_sched

---
 rtl/esp_trees_pkg.sv | 31 +++
 rtl/esp_trees_dma_req.sv | 49 ++++
 rtl/esp_trees_sched.sv | 181 ++++++++++++++++++
 tb/tb_esp_trees_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esp_trees_pkg.sv
// Shared types and constants for the ESP tree-ensemble DMA scheduler.
// Holds the FSM state encoding, DMA size codes and the burst sizing helper.
package esp_trees_pkg;

  localparam int N_TREES          = 128;
  localparam int N_NODES          = 256;
  localparam int N_FEATURE        = 32;
  localparam int MAX_BURST        = 64;
  localparam int BEATS_PER_SAMPLE = N_FEATURE / 2;

  localparam logic [31:0] TREE_BEATS = 32'(N_TREES * N_NODES);
  localparam logic [2:0]  SIZE_WORD  = 3'd2;
  localparam logic [2:0]  SIZE_DWORD = 3'd3;

  typedef enum logic [3:0] {
    IDLE,
    TREE_REQ,
    TREE_DATA,
    FEAT_REQ,
    FEAT_DATA,
    RUN,
    WR_REQ,
    WR_DATA,
    DONE
  } state_t;

  function automatic logic [6:0] burstOf(input logic [31:0] remaining);
    return (remaining > 32'(MAX_BURST)) ? 7'(MAX_BURST) : remaining[6:0];
  endfunction

endpackage

// File: rtl/esp_trees_dma_req.sv
// DMA control-channel request register: captures a request one cycle after
// i_req rises and holds it stable until the valid/ready handshake completes.
module esp_trees_dma_req (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_index,
  input  logic [31:0] i_length,
  input  logic [2:0]  i_size,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_index,
  output logic [31:0] o_length,
  output logic [2:0]  o_size,
  output logic        o_fire
);

  logic        r_valid;
  logic [31:0] r_index;
  logic [31:0] r_length;
  logic [2:0]  r_size;

  assign o_fire   = r_valid & i_ready;
  assign o_valid  = r_valid;
  assign o_index  = r_index;
  assign o_length = r_length;
  assign o_size   = r_size;

  // Fields read back as zero whenever no request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_index  <= '0;
      r_length <= '0;
      r_size   <= '0;
    end else if (o_fire) begin
      r_valid  <= 1'b0;
      r_index  <= '0;
      r_length <= '0;
      r_size   <= '0;
    end else if (i_req && !r_valid) begin
      r_valid  <= 1'b1;
      r_index  <= i_index;
      r_length <= i_length;
      r_size   <= i_size;
    end
  end

endmodule

// File: rtl/esp_trees_sched.sv
// Job scheduler for the tree-ensemble accelerator: sequences tree loading and
// burst-wise feature read, core run and result write-back over DMA.
module esp_trees_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_conf_done,
  input  logic        i_load_trees,
  input  logic [31:0] i_n_samples,
  input  logic [31:0] i_rd_base,
  input  logic [31:0] i_wr_base,
  output logic        o_dma_read_ctrl_valid,
  input  logic        i_dma_read_ctrl_ready,
  output logic [31:0] o_dma_read_ctrl_data_index,
  output logic [31:0] o_dma_read_ctrl_data_length,
  output logic [2:0]  o_dma_read_ctrl_data_size,
  input  logic        i_dma_read_chnl_valid,
  input  logic        i_core_rd_ready,
  output logic        o_dma_read_chnl_ready,
  output logic        o_core_start,
  output logic [6:0]  o_core_burst_len,
  output logic        o_core_load_trees,
  input  logic        i_core_done,
  output logic        o_dma_write_ctrl_valid,
  input  logic        i_dma_write_ctrl_ready,
  output logic [31:0] o_dma_write_ctrl_data_index,
  output logic [31:0] o_dma_write_ctrl_data_length,
  output logic [2:0]  o_dma_write_ctrl_data_size,
  input  logic        i_wr_beat,
  output logic        o_acc_done,
  output logic        o_busy
);

  import esp_trees_pkg::*;

  state_t      r_state;
  logic [15:0] r_beatCnt;
  logic [31:0] r_featOff;
  logic [31:0] r_sampOff;
  logic [31:0] r_remaining;
  logic [6:0]  r_burst;
  logic [31:0] r_rdBase;
  logic [31:0] r_wrBase;
  logic        r_coreStart;
  logic [6:0]  r_coreBurstLen;
  logic        r_coreLoadTrees;
  logic        r_accDone;

  logic        w_rdFire;
  logic        w_wrFire;
  logic        w_rdBeat;
  logic [15:0] w_cntNext;
  logic [15:0] w_featBeats;
  logic [31:0] w_remNext;
  logic        w_rdReq;
  logic [31:0] w_rdIndex;
  logic [31:0] w_rdLength;

  assign w_featBeats = 16'(r_burst) * 16'(BEATS_PER_SAMPLE);
  assign w_cntNext   = r_beatCnt + 16'd1;
  assign w_remNext   = r_remaining - 32'(r_burst);
  assign w_rdBeat    = i_dma_read_chnl_valid & o_dma_read_chnl_ready;
  assign w_rdReq     = (r_state == TREE_REQ) | (r_state == FEAT_REQ);
  assign w_rdIndex   = (r_state == TREE_REQ) ? r_rdBase : r_rdBase + r_featOff;
  assign w_rdLength  = (r_state == TREE_REQ) ? TREE_BEATS : 32'(w_featBeats);

  assign o_dma_read_chnl_ready = i_core_rd_ready &
                                 ((r_state == TREE_DATA) | (r_state == FEAT_DATA));
  assign o_core_start      = r_coreStart;
  assign o_core_burst_len  = r_coreBurstLen;
  assign o_core_load_trees = r_coreLoadTrees;
  assign o_acc_done        = r_accDone;
  assign o_busy            = (r_state != IDLE);

  esp_trees_dma_req u_rdReq (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_rdReq),
    .i_index  (w_rdIndex),
    .i_length (w_rdLength),
    .i_size   (SIZE_DWORD),
    .i_ready  (i_dma_read_ctrl_ready),
    .o_valid  (o_dma_read_ctrl_valid),
    .o_index  (o_dma_read_ctrl_data_index),
    .o_length (o_dma_read_ctrl_data_length),
    .o_size   (o_dma_read_ctrl_data_size),
    .o_fire   (w_rdFire)
  );

  esp_trees_dma_req u_wrReq (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (r_state == WR_REQ),
    .i_index  (r_wrBase + r_sampOff),
    .i_length (32'(r_burst)),
    .i_size   (SIZE_WORD),
    .i_ready  (i_dma_write_ctrl_ready),
    .o_valid  (o_dma_write_ctrl_valid),
    .o_index  (o_dma_write_ctrl_data_index),
    .o_length (o_dma_write_ctrl_data_length),
    .o_size   (o_dma_write_ctrl_data_size),
    .o_fire   (w_wrFire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_beatCnt       <= '0;
      r_featOff       <= '0;
      r_sampOff       <= '0;
      r_remaining     <= '0;
      r_burst         <= '0;
      r_rdBase        <= '0;
      r_wrBase        <= '0;
      r_coreStart     <= 1'b0;
      r_coreBurstLen  <= '0;
      r_coreLoadTrees <= 1'b0;
      r_accDone       <= 1'b0;
    end else begin
      r_coreStart <= 1'b0;
      r_accDone   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_beatCnt <= '0;
          if (i_conf_done) begin
            r_rdBase    <= i_rd_base;
            r_wrBase    <= i_wr_base;
            r_featOff   <= '0;
            r_sampOff   <= '0;
            r_remaining <= i_n_samples;
            r_burst     <= burstOf(i_n_samples);
            if (i_load_trees)             r_state <= TREE_REQ;
            else if (i_n_samples != 32'd0) r_state <= FEAT_REQ;
            else                           r_state <= DONE;
          end
        end
        TREE_REQ: if (w_rdFire) begin
          r_state         <= TREE_DATA;
          r_coreLoadTrees <= 1'b1;
        end
        TREE_DATA: if (w_rdBeat) begin
          r_beatCnt <= w_cntNext;
          if (w_cntNext == 16'(TREE_BEATS)) begin
            r_beatCnt       <= '0;
            r_coreLoadTrees <= 1'b0;
            r_state         <= DONE;
          end
        end
        FEAT_REQ: if (w_rdFire) r_state <= FEAT_DATA;
        FEAT_DATA: if (w_rdBeat) begin
          r_beatCnt <= w_cntNext;
          if (w_cntNext == w_featBeats) begin
            r_beatCnt      <= '0;
            r_coreStart    <= 1'b1;
            r_coreBurstLen <= r_burst;
            r_state        <= RUN;
          end
        end
        RUN: if (i_core_done) r_state <= WR_REQ;
        WR_REQ: if (w_wrFire) r_state <= WR_DATA;
        // Offsets advance only once the whole burst has been written back.
        WR_DATA: if (i_wr_beat) begin
          r_beatCnt <= w_cntNext;
          if (w_cntNext == 16'(r_burst)) begin
            r_beatCnt   <= '0;
            r_featOff   <= r_featOff + 32'(w_featBeats);
            r_sampOff   <= r_sampOff + 32'(r_burst);
            r_remaining <= w_remNext;
            r_burst     <= burstOf(w_remNext);
            r_state     <= (w_remNext != 32'd0) ? FEAT_REQ : DONE;
          end
        end
        DONE: begin
          r_accDone <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esp_trees_sched.sv
// Self-checking bench for esp_trees_sched: a DMA/core responder records every
// request, and a burst-splitting reference model predicts what should be seen.
module tb_esp_trees_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_conf_done, i_load_trees;
  logic [31:0] i_n_samples, i_rd_base, i_wr_base;
  logic        o_dma_read_ctrl_valid, i_dma_read_ctrl_ready;
  logic [31:0] o_dma_read_ctrl_data_index, o_dma_read_ctrl_data_length;
  logic [2:0]  o_dma_read_ctrl_data_size;
  logic        i_dma_read_chnl_valid, i_core_rd_ready, o_dma_read_chnl_ready;
  logic        o_core_start, o_core_load_trees, i_core_done;
  logic [6:0]  o_core_burst_len;
  logic        o_dma_write_ctrl_valid, i_dma_write_ctrl_ready;
  logic [31:0] o_dma_write_ctrl_data_index, o_dma_write_ctrl_data_length;
  logic [2:0]  o_dma_write_ctrl_data_size;
  logic        i_wr_beat, o_acc_done, o_busy;
  logic [147:0] allOutputs;

  always #5 clk = ~clk;

  esp_trees_sched dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .i_conf_done                  (i_conf_done),
    .i_load_trees                 (i_load_trees),
    .i_n_samples                  (i_n_samples),
    .i_rd_base                    (i_rd_base),
    .i_wr_base                    (i_wr_base),
    .o_dma_read_ctrl_valid        (o_dma_read_ctrl_valid),
    .i_dma_read_ctrl_ready        (i_dma_read_ctrl_ready),
    .o_dma_read_ctrl_data_index   (o_dma_read_ctrl_data_index),
    .o_dma_read_ctrl_data_length  (o_dma_read_ctrl_data_length),
    .o_dma_read_ctrl_data_size    (o_dma_read_ctrl_data_size),
    .i_dma_read_chnl_valid        (i_dma_read_chnl_valid),
    .i_core_rd_ready              (i_core_rd_ready),
    .o_dma_read_chnl_ready        (o_dma_read_chnl_ready),
    .o_core_start                 (o_core_start),
    .o_core_burst_len             (o_core_burst_len),
    .o_core_load_trees            (o_core_load_trees),
    .i_core_done                  (i_core_done),
    .o_dma_write_ctrl_valid       (o_dma_write_ctrl_valid),
    .i_dma_write_ctrl_ready       (i_dma_write_ctrl_ready),
    .o_dma_write_ctrl_data_index  (o_dma_write_ctrl_data_index),
    .o_dma_write_ctrl_data_length (o_dma_write_ctrl_data_length),
    .o_dma_write_ctrl_data_size   (o_dma_write_ctrl_data_size),
    .i_wr_beat                    (i_wr_beat),
    .o_acc_done                   (o_acc_done),
    .o_busy                       (o_busy)
  );

  assign allOutputs = {o_dma_read_ctrl_valid, o_dma_read_ctrl_data_index,
                       o_dma_read_ctrl_data_length, o_dma_read_ctrl_data_size,
                       o_dma_read_chnl_ready, o_core_start, o_core_burst_len,
                       o_core_load_trees, o_dma_write_ctrl_valid,
                       o_dma_write_ctrl_data_index, o_dma_write_ctrl_data_length,
                       o_dma_write_ctrl_data_size, o_acc_done, o_busy};

  typedef struct {
    logic [31:0] nSamples;
    logic [31:0] rdBase;
    logic [31:0] wrBase;
    int          rdDelay;
    int          wrDelay;
    bit          pulseInRun;
    int          expBursts;
    int          expRdBeats;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int rdPend, wrPend, rdWait, wrWait, runWait, rdBeats, accCnt;
  int cyc = 0, lastBeatCyc, accCyc, stableErr, runReadyErr;
  int rdDelay = 0, wrDelay = 0;
  bit coreBusy, ctrlValidSeen, loadTreesSeen, fastRead, prevPending;
  logic [31:0] prevIdx, prevLen;
  logic [31:0] rdIdxQ[$], rdLenQ[$], rdSizeQ[$];
  logic [31:0] wrIdxQ[$], wrLenQ[$], wrSizeQ[$], burstQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearLogs();
    rdIdxQ.delete(); rdLenQ.delete(); rdSizeQ.delete();
    wrIdxQ.delete(); wrLenQ.delete(); wrSizeQ.delete(); burstQ.delete();
    rdBeats = 0; accCnt = 0; lastBeatCyc = 0; accCyc = 0;
    stableErr = 0; runReadyErr = 0;
    ctrlValidSeen = 0; loadTreesSeen = 0;
  endtask

  // Observer: everything that will handshake at the coming rising edge.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      rdPend = 0; wrPend = 0; coreBusy = 0; prevPending = 0;
    end else begin
      if (o_dma_read_ctrl_valid || o_dma_write_ctrl_valid) ctrlValidSeen = 1;
      if (o_core_load_trees) loadTreesSeen = 1;
      if (prevPending && o_dma_read_ctrl_valid &&
          (o_dma_read_ctrl_data_index != prevIdx || o_dma_read_ctrl_data_length != prevLen))
        stableErr++;
      prevPending = o_dma_read_ctrl_valid && !i_dma_read_ctrl_ready;
      prevIdx = o_dma_read_ctrl_data_index;
      prevLen = o_dma_read_ctrl_data_length;
      if (o_dma_read_ctrl_valid && i_dma_read_ctrl_ready) begin
        rdIdxQ.push_back(o_dma_read_ctrl_data_index);
        rdLenQ.push_back(o_dma_read_ctrl_data_length);
        rdSizeQ.push_back(32'(o_dma_read_ctrl_data_size));
        rdPend += int'(o_dma_read_ctrl_data_length);
      end
      if (i_dma_read_chnl_valid && o_dma_read_chnl_ready) begin
        rdBeats++; rdPend--; lastBeatCyc = cyc;
      end
      if (o_dma_write_ctrl_valid && i_dma_write_ctrl_ready) begin
        wrIdxQ.push_back(o_dma_write_ctrl_data_index);
        wrLenQ.push_back(o_dma_write_ctrl_data_length);
        wrSizeQ.push_back(32'(o_dma_write_ctrl_data_size));
        wrPend += int'(o_dma_write_ctrl_data_length);
      end
      if (i_wr_beat) wrPend--;
      if (o_core_start) begin
        burstQ.push_back(32'(o_core_burst_len));
        coreBusy = 1;
        runWait = $urandom_range(0, 4);
      end
      if (coreBusy && o_dma_read_chnl_ready) runReadyErr++;
      if (o_acc_done) begin accCnt++; accCyc = cyc; end
    end
  end

  // Responder: DMA engine and inference core, driven just after each edge.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (!rst_n) begin
      i_dma_read_ctrl_ready = 0; i_dma_write_ctrl_ready = 0;
      i_dma_read_chnl_valid = 0; i_core_rd_ready = 0;
      i_core_done = 0; i_wr_beat = 0; rdWait = 0; wrWait = 0;
    end else begin
      if (o_dma_read_ctrl_valid) begin
        i_dma_read_ctrl_ready = (rdWait >= rdDelay); rdWait++;
      end else begin
        i_dma_read_ctrl_ready = 0; rdWait = 0;
      end
      if (o_dma_write_ctrl_valid) begin
        i_dma_write_ctrl_ready = (wrWait >= wrDelay); wrWait++;
      end else begin
        i_dma_write_ctrl_ready = 0; wrWait = 0;
      end
      i_core_done = 0;
      if (coreBusy) begin
        if (runWait == 0) begin i_core_done = 1; coreBusy = 0; end
        else runWait--;
      end else if (rdPend > 0 && $urandom_range(0, 15) == 0) begin
        i_core_done = 1;
      end
      if (fastRead) begin
        i_core_rd_ready = 1;
        i_dma_read_chnl_valid = (rdPend > 0);
      end else begin
        i_core_rd_ready = ($urandom_range(0, 3) != 0);
        i_dma_read_chnl_valid = coreBusy || (rdPend > 0 && $urandom_range(0, 3) != 0);
      end
      i_wr_beat = (wrPend > 0) && ($urandom_range(0, 3) != 0);
    end
  end

  task automatic startJob(input bit loadTrees, input logic [31:0] n,
                          input logic [31:0] rdBase, input logic [31:0] wrBase);
    @(posedge clk); #1;
    clearLogs();
    i_conf_done = 1; i_load_trees = loadTrees;
    i_n_samples = n; i_rd_base = rdBase; i_wr_base = wrBase;
    @(posedge clk); #1;
    i_conf_done = 0; i_load_trees = 1'($urandom);
    i_n_samples = $urandom; i_rd_base = $urandom; i_wr_base = $urandom;
  endtask

  task automatic waitAcc(input int budget, input bit pulseInRun);
    int k = 0;
    bit pulsed = 0;
    while (accCnt == 0 && k < budget) begin
      @(posedge clk); #1;
      i_conf_done = 0;
      if (pulseInRun && coreBusy && !pulsed) begin
        i_conf_done = 1; pulsed = 1;
      end
      k++;
    end
    i_conf_done = 0;
    if (accCnt == 0) checkOutput("accDoneTimeout", 32'(accCnt), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("accDoneCount", 32'(accCnt), 32'd1);
    checkOutput("busyAfterJob", 32'(o_busy), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    rdDelay = v.rdDelay; wrDelay = v.wrDelay; fastRead = 0;
    startJob(1'b0, v.nSamples, v.rdBase, v.wrBase);
    waitAcc(20000, v.pulseInRun);
  endtask

  // Reference: split the job into bursts of at most 64 samples.
  task automatic checkJob(input vec_t v);
    logic [31:0] rem, done, b;
    int k = 0;
    checkOutput("rdReqCount", 32'(rdIdxQ.size()), 32'(v.expBursts));
    checkOutput("wrReqCount", 32'(wrIdxQ.size()), 32'(v.expBursts));
    checkOutput("burstCount", 32'(burstQ.size()), 32'(v.expBursts));
    rem = v.nSamples; done = 0;
    while (rem != 0) begin
      b = (rem > 32'd64) ? 32'd64 : rem;
      if (k < rdIdxQ.size()) begin
        checkOutput($sformatf("rdIdx[%0d]", k), rdIdxQ[k], v.rdBase + done * 32'd16);
        checkOutput($sformatf("rdLen[%0d]", k), rdLenQ[k], b * 32'd16);
        checkOutput($sformatf("rdSize[%0d]", k), rdSizeQ[k], 32'd3);
      end
      if (k < wrIdxQ.size()) begin
        checkOutput($sformatf("wrIdx[%0d]", k), wrIdxQ[k], v.wrBase + done);
        checkOutput($sformatf("wrLen[%0d]", k), wrLenQ[k], b);
        checkOutput($sformatf("wrSize[%0d]", k), wrSizeQ[k], 32'd2);
      end
      if (k < burstQ.size())
        checkOutput($sformatf("burstLen[%0d]", k), burstQ[k], b);
      done = done + b; rem = rem - b; k++;
    end
    checkOutput("rdBeats", 32'(rdBeats), 32'(v.expRdBeats));
    checkOutput("chnlReadyInRun", 32'(runReadyErr), 32'd0);
    checkOutput("ctrlHeldStable", 32'(stableErr), 32'd0);
    checkOutput("loadTreesInInference", 32'(loadTreesSeen), 32'd0);
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int n;
    vecs[0] = '{32'd130, 32'h0, 32'h0, 0, 0, 1'b0, 3, 2080};
    vecs[1] = '{32'd1, 32'h100, 32'h200, 2, 1, 1'b0, 1, 16};
    vecs[2] = '{32'd65, 32'hFFFF_FC00, 32'hFFFF_FFF0, 1, 0, 1'b1, 2, 1040};
    vecs[3] = '{32'd0, 32'h10, 32'h20, 0, 0, 1'b0, 0, 0};
    n = $urandom_range(1, 100);
    vecs[4] = '{32'(n), $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3), 1'b1, (n + 63) / 64, n * 16};
    vecs[5] = '{32'd128, 32'h40, 32'h80, 0, 0, 1'b0, 2, 2048};

    rst_n = 0; i_conf_done = 0; i_load_trees = 0;
    i_n_samples = 0; i_rd_base = 0; i_wr_base = 0; fastRead = 0;
    clearLogs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutputsZero", 32'(|allOutputs), 32'd0);

    // Empty job accepted on the first edge after reset release.
    rst_n = 1; i_conf_done = 1; i_n_samples = 0; i_load_trees = 0;
    @(posedge clk); #1;
    i_conf_done = 0;
    checkOutput("busyAfterFirstEdge", 32'(o_busy), 32'd1);
    checkOutput("accDoneEmptyCycle1", 32'(o_acc_done), 32'd0);
    @(posedge clk); #1;
    checkOutput("accDoneEmptyCycle2", 32'(o_acc_done), 32'd1);
    @(posedge clk); #1;
    checkOutput("accDonePulseWidth", 32'(o_acc_done), 32'd0);
    checkOutput("busyBackIdle", 32'(o_busy), 32'd0);
    checkOutput("noCtrlValidEmpty", 32'(ctrlValidSeen), 32'd0);

    // Tree load with a slow read-control ready.
    rdDelay = 3; fastRead = 1;
    startJob(1'b1, 32'd0, 32'd0, 32'd0);
    waitAcc(40000, 1'b0);
    checkOutput("treeRdReqCount", 32'(rdIdxQ.size()), 32'd1);
    if (rdIdxQ.size() > 0) begin
      checkOutput("treeRdIdx", rdIdxQ[0], 32'd0);
      checkOutput("treeRdLen", rdLenQ[0], 32'd32768);
      checkOutput("treeRdSize", rdSizeQ[0], 32'd3);
    end
    checkOutput("treeWrReqCount", 32'(wrIdxQ.size()), 32'd0);
    checkOutput("treeBeats", 32'(rdBeats), 32'd32768);
    checkOutput("treeAccLatency", 32'(accCyc - lastBeatCyc), 32'd2);
    checkOutput("treeLoadSeen", 32'(loadTreesSeen), 32'd1);
    checkOutput("treeLoadCleared", 32'(o_core_load_trees), 32'd0);
    checkOutput("treeNoCoreStart", 32'(burstQ.size()), 32'd0);
    checkOutput("treeCtrlStable", 32'(stableErr), 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkJob(vecs[i]);
    end

    // Reset in the middle of the second burst's feature read.
    rdDelay = 0; wrDelay = 0; fastRead = 0;
    startJob(1'b0, 32'd130, 32'h40, 32'h80);
    for (int k = 0; k < 20000; k++) begin
      if (rdIdxQ.size() >= 2 && rdBeats >= 1044) break;
      @(posedge clk); #1;
    end
    checkOutput("reachedBurst2Data", 32'(rdBeats >= 1044), 32'd1);
    rst_n = 0;
    #1;
    checkOutput("midBurstResetOutputs", 32'(|allOutputs), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clearLogs();
    rst_n = 1; i_conf_done = 1; i_load_trees = 0;
    i_n_samples = 32'd5; i_rd_base = 32'h1234; i_wr_base = 32'h55;
    @(posedge clk); #1;
    i_conf_done = 0; i_n_samples = $urandom; i_rd_base = $urandom;
    waitAcc(20000, 1'b0);
    v = '{32'd5, 32'h1234, 32'h55, 0, 0, 1'b0, 1, 80};
    checkJob(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
